// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: 5-stage RISC-V hazard unit with E/D forwarding,
// load-use stall, branch flush, and a scoreboard for one outstanding
// multi-cycle MDU op (mul/div) that writes through its own register port.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating performance
// counters PerfStall, PerfFlush and PerfMdu.
module hazard_scoreboard_unit #(
  parameter  int REG_AW  = 5,
  parameter  int MDU_LAT = 4,
  localparam int CNT_W   = $clog2(MDU_LAT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Ra1D,
  input  logic [REG_AW-1:0] Ra2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              MduReqD,
  input  logic [REG_AW-1:0] Ra1E,
  input  logic [REG_AW-1:0] Ra2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ResultSrcE,
  input  logic              MduStartE,
  input  logic [1:0]        PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [1:0]        ForwardAD,
  output logic [1:0]        ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MduBusy,
  output logic              MduDone,
  output logic [REG_AW-1:0] MduRd
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       PerfStall,
  output logic [31:0]       PerfFlush,
  output logic [31:0]       PerfMdu
`endif
);

  // Scoreboard state
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [REG_AW-1:0] rd_q,   rd_d;

  logic done;
  logic lw_stall, iss_stall, sb_stall, stall, redir;
  logic accept;

  // Pipeline-register forwarding select: M beats W, x0 never forwards.
  function automatic logic [1:0] fwd_mw(input logic [REG_AW-1:0] src,
                                        input logic [REG_AW-1:0] rd_m,
                                        input logic              we_m,
                                        input logic [REG_AW-1:0] rd_w,
                                        input logic              we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0 && we_m && src == rd_m)      sel = 2'b10;
    else if (src != '0 && we_w && src == rd_w) sel = 2'b01;
    return sel;
  endfunction

  // Done is a pure function of registered state.
  always_comb begin
    done    = busy_q && (cnt_q == '0);
    MduBusy = busy_q;
    MduDone = done;
    MduRd   = rd_q;
  end

  // Operand forwarding for E and D stages; MDU completion has top priority in D.
  always_comb begin
    ForwardAE = fwd_mw(Ra1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_mw(Ra2E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardAD = fwd_mw(Ra1D, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBD = fwd_mw(Ra2D, RdM, RegWriteM, RdW, RegWriteW);
    if (done && Ra1D != '0 && Ra1D == rd_q) ForwardAD = 2'b11;
    if (done && Ra2D != '0 && Ra2D == rd_q) ForwardBD = 2'b11;
  end

  // Stall/flush generation; a redirect squashes the stalled D instruction.
  always_comb begin
    lw_stall  = ResultSrcE && (RdE != '0) && (Ra1D == RdE || Ra2D == RdE);
    iss_stall = MduStartE && (MduReqD ||
                ((RdE != '0) && (Ra1D == RdE || Ra2D == RdE || RdD == RdE)));
    sb_stall  = busy_q && !done && (MduReqD ||
                ((rd_q != '0) && (Ra1D == rd_q || Ra2D == rd_q || RdD == rd_q)));
    stall     = lw_stall || iss_stall || sb_stall;
    redir     = (PCSrcE != 2'b00);
    StallF    = stall && !redir;
    StallD    = stall && !redir;
    FlushD    = redir;
    FlushE    = redir || stall;
  end

  // Scoreboard next state: a new issue on the done cycle reloads without a gap.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    accept = MduStartE && (!busy_q || done);
    if (busy_q && !done) cnt_d = cnt_q - CNT_W'(1);
    if (done)            busy_d = 1'b0;
    if (accept) begin
      busy_d = 1'b1;
      rd_d   = RdE;
      cnt_d  = CNT_W'(MDU_LAT - 1);
    end
  end

  // Scoreboard registers; reset abandons any outstanding op immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
    end
  end

  // An issue while an op is still in flight means the stall logic was bypassed.
  a_no_issue_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(MduStartE && busy_q && !done));

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_mdu_q,   perf_mdu_d;

  // Saturating event counters.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_mdu_d   = perf_mdu_q;
    if (StallF && perf_stall_q != '1)                  perf_stall_d = perf_stall_q + 32'd1;
    if (FlushD && perf_flush_q != '1)                  perf_flush_d = perf_flush_q + 32'd1;
    if ((sb_stall || iss_stall) && perf_mdu_q != '1)   perf_mdu_d   = perf_mdu_q + 32'd1;
    PerfStall = perf_stall_q;
    PerfFlush = perf_flush_q;
    PerfMdu   = perf_mdu_q;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_mdu_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_mdu_q   <= perf_mdu_d;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (MDU_LAT = 4).
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Ra1D, Ra2D, RdD, Ra1E, Ra2E, RdE, RdM, RdW;
  logic       MduReqD, ResultSrcE, MduStartE, RegWriteM, RegWriteW;
  logic [1:0] PCSrcE;
  logic [1:0] ForwardAE, ForwardBE, ForwardAD, ForwardBD;
  logic       StallF, StallD, FlushD, FlushE, MduBusy, MduDone;
  logic [4:0] MduRd;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard_unit #(.REG_AW(5), .MDU_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .Ra1D(Ra1D), .Ra2D(Ra2D), .RdD(RdD), .MduReqD(MduReqD),
    .Ra1E(Ra1E), .Ra2E(Ra2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
    .MduStartE(MduStartE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .MduBusy(MduBusy), .MduDone(MduDone), .MduRd(MduRd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    Ra1D = '0; Ra2D = '0; RdD = '0; MduReqD = 1'b0;
    Ra1E = '0; Ra2E = '0; RdE = '0; ResultSrcE = 1'b0; MduStartE = 1'b0;
    PCSrcE = 2'b00; RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  // Advance one clock; inputs are changed 1 ns after the edge, checks 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    #2;
    chk("rst_busy", MduBusy, 0);
    chk("rst_done", MduDone, 0);
    chk("rst_rd", MduRd, 0);
    chk("rst_stallf", StallF, 0);
    chk("rst_flushe", FlushE, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Forwarding priority
    RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Ra1E = 5; Ra2E = 5; Ra1D = 5;
    #1;
    chk("fwd_ae_m", ForwardAE, 2'b10);
    chk("fwd_be_m", ForwardBE, 2'b10);
    chk("fwd_ad_m", ForwardAD, 2'b10);
    RegWriteM = 0; #1;
    chk("fwd_ae_w", ForwardAE, 2'b01);
    chk("fwd_ad_w", ForwardAD, 2'b01);
    Ra1E = 0; #1;
    chk("fwd_ae_x0", ForwardAE, 2'b00);
    chk("fwd_be_w", ForwardBE, 2'b01);
    clr(); tick();

    // Load-use stall
    ResultSrcE = 1; RdE = 7; Ra2D = 7; #1;
    chk("lw_stallf", StallF, 1);
    chk("lw_stalld", StallD, 1);
    chk("lw_flushe", FlushE, 1);
    chk("lw_flushd", FlushD, 0);
    RdE = 0; Ra2D = 0; Ra1D = 0; #1;
    chk("lw_x0_stallf", StallF, 0);
    chk("lw_x0_flushe", FlushE, 0);
    // Redirect wins over load-use stall
    RdE = 7; Ra2D = 7; PCSrcE = 2'b01; #1;
    chk("redir_stallf", StallF, 0);
    chk("redir_stalld", StallD, 0);
    chk("redir_flushd", FlushD, 1);
    chk("redir_flushe", FlushE, 1);
    clr(); tick();

    // MDU RAW: issue rd=9 with dependent D instruction
    MduStartE = 1; RdE = 9; Ra1D = 9; #1;
    chk("raw_iss_stall", StallF, 1);
    chk("raw_iss_busy", MduBusy, 0);
    tick();
    MduStartE = 0; RdE = 0; #1;
    chk("raw_busy", MduBusy, 1);
    chk("raw_rd", MduRd, 9);
    for (int i = 0; i < 3; i++) begin
      chk("raw_sb_stall", StallF, 1);
      chk("raw_sb_done", MduDone, 0);
      if (i < 2) tick();
    end
    tick();
    Ra2D = 9; #1;
    chk("raw_done", MduDone, 1);
    chk("raw_fwd_ad", ForwardAD, 2'b11);
    chk("raw_fwd_bd", ForwardBD, 2'b11);
    chk("raw_done_nostall", StallF, 0);
    tick();
    chk("raw_after_busy", MduBusy, 0);
    chk("raw_after_done", MduDone, 0);
    chk("raw_after_rd", MduRd, 9);
    chk("raw_after_fwd", ForwardAD, 2'b00);
    clr(); tick();

    // Structural: MDU busy (rd=3), D instruction is an MDU op
    MduStartE = 1; RdE = 3; #1;
    chk("str_iss_nostall", StallF, 0);
    tick();
    MduStartE = 0; RdE = 0; MduReqD = 1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("str_stall", StallF, 1);
      tick();
    end
    chk("str_done", MduDone, 1);
    chk("str_done_nostall", StallF, 0);
    tick();
    chk("str_idle", MduBusy, 0);
    clr(); tick();

    // WAW with redirect mid-op, then back-to-back issue on done
    MduStartE = 1; RdE = 3; #1;
    chk("waw_iss_nostall", StallF, 0);
    tick();
    MduStartE = 0; RdE = 0; RdD = 3; #1;
    chk("waw_stall0", StallD, 1);
    tick();
    chk("waw_stall1", StallD, 1);
    tick();
    PCSrcE = 2'b10; #1;
    chk("waw_redir_stall", StallF, 0);
    chk("waw_redir_flushd", FlushD, 1);
    chk("waw_redir_busy", MduBusy, 1);
    tick();
    PCSrcE = 2'b00; MduStartE = 1; RdE = 4; #1;
    chk("waw_done_sched", MduDone, 1);
    chk("b2b_nostall", StallF, 0);
    tick();
    MduStartE = 0; RdE = 0; #1;
    chk("b2b_busy", MduBusy, 1);
    chk("b2b_rd", MduRd, 4);
    chk("b2b_done", MduDone, 0);
    tick(); tick();

    // Asynchronous reset mid-op, away from any clock edge
    reset = 1'b1; #1;
    chk("arst_busy", MduBusy, 0);
    chk("arst_done", MduDone, 0);
    chk("arst_rd", MduRd, 0);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_done", MduDone, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Next-generation hazard unit for the 5-stage RISC-V pipeline.
- Keeps E- and D-stage forwarding, load-use stall and branch flush.
- Adds a registered scoreboard and latency counter for one outstanding multi-cycle MDU op (mul/div).
- The MDU writes the register file through a dedicated write port; this block tracks the pending destination, stalls dependent instructions, and forwards the MDU result on its completion cycle.

Parameters:
- REG_AW, 5, register address width.
- MDU_LAT, 4, cycles from MDU issue to result valid; legal range is 2 to 64.
- CNT_W, $clog2(MDU_LAT+1), latency counter width; derived, do not override.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Ra1D, Ra2D, RdD  in  REG_AW each  D-stage source and destination registers.
- MduReqD  in  1  D-stage instruction is an MDU op.
- Ra1E, Ra2E, RdE  in  REG_AW each  E-stage sources and destination.
- ResultSrcE  in  1  E-stage instruction is a load.
- MduStartE  in  1  E-stage instruction is an MDU op; issues this cycle.
- PCSrcE  in  2  non-zero means redirect (branch/jump taken).
- RdM, RdW  in  REG_AW each  M/W destinations.
- RegWriteM, RegWriteW  in  1 each  M/W write enables.
- ForwardAE, ForwardBE  out  2 each  E-stage operand select.
- ForwardAD, ForwardBD  out  2 each  D-stage operand select.
- StallF, StallD  out  1 each  hold PC and IF/ID.
- FlushD, FlushE  out  1 each  bubble IF/ID and ID/EX.
- MduBusy  out  1  MDU op outstanding.
- MduDone  out  1  one-cycle pulse; MDU result valid and written this cycle.
- MduRd  out  REG_AW  pending MDU destination.

Behaviour:
- Reset: MduBusy=0, counter=0, MduRd=0, MduDone=0.
  - All combinational outputs follow from the reset state: stalls and flushes are 0 unless PCSrcE≠0; forwards follow their inputs.
- E forwarding, for each of Ra1E/Ra2E (src):
  - 10 when src==RdM, RegWriteM and src≠0.
  - else 01 when src==RdW, RegWriteW and src≠0.
  - else 00.
  - M has priority over W.
- D forwarding, for each of Ra1D/Ra2D:
  - 11 when MduDone, src==MduRd and src≠0 (highest priority).
  - else 10 or 01 by the same rules as E forwarding.
  - else 00.
- lwStall = ResultSrcE & RdE≠0 & (Ra1D==RdE | Ra2D==RdE).
  - RdE==0 never stalls; this fixes the x0 hole.
- issStall = MduStartE & (MduReqD | (RdE≠0 & (Ra1D==RdE | Ra2D==RdE | RdD==RdE))).
  - Covers RAW, WAW and structural conflicts against the op issuing this cycle.
- sbStall = MduBusy & ~MduDone & (MduReqD | (MduRd≠0 & (Ra1D==MduRd | Ra2D==MduRd | RdD==MduRd))).
- stall = lwStall | issStall | sbStall; redir = (PCSrcE≠00).
- Outputs:
  - StallF = StallD = stall & ~redir. A redirect squashes the stalled D instruction, so the redirect wins.
  - FlushD = redir.
  - FlushE = redir | stall.
- Scoreboard sequential behaviour:
  - On a posedge with MduStartE & ~MduBusy: MduBusy←1, MduRd←RdE, counter←MDU_LAT-1.
  - While busy: counter decrements by 1 each cycle. MduDone = MduBusy & (counter==0), combinational from state.
  - On the done cycle: next posedge clears MduBusy. MduRd holds its value until the next issue.
  - Net timing: issue accepted at edge t, MduBusy high for MDU_LAT cycles, MduDone in the last of them.
- Back-to-back issue:
  - A new MduStartE may coincide with MduDone; it is accepted and reloads the counter with no idle cycle.
  - MduStartE while busy and not done is impossible because issStall/sbStall block it. A simulation assertion flags it; RTL ignores it.
- Redirect does not cancel an outstanding MDU op, because that op is older than the branch.
- Reset asserted mid-op: the op is abandoned and the state returns to reset values immediately (async).

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, add three 32-bit saturating counters, reset to 0:
  - StallCycles: counts cycles where StallF=1.
  - FlushCycles: counts cycles where FlushD=1.
  - MduStallCycles: counts cycles where sbStall|issStall.
  - Exposed as outputs PerfStall, PerfFlush, PerfMdu; each saturates at 32'hFFFFFFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Forwarding priority: RdM=RdW=5, RegWriteM=RegWriteW=1, Ra1E=5 -> ForwardAE=10. Same with RegWriteM=0 -> 01. Ra1E=0 -> 00.
- Load-use: ResultSrcE=1, RdE=7, Ra2D=7 -> StallF=StallD=FlushE=1 for one cycle. RdE=0 with Ra1D=0 -> no stall.
- MDU RAW, MDU_LAT=4: issue MduStartE with RdE=9, then next D instruction has Ra1D=9.
  - issStall in the issue cycle; sbStall for 3 cycles.
  - MduDone in cycle 4 with ForwardAD=11 and no stall; MduBusy=0 after.
- Structural/WAW: MDU busy with MduRd=3. D has MduReqD=1 -> stall until MduDone. D has RdD=3 -> stall likewise.
- Redirect over stall: lwStall active and PCSrcE=01 in the same cycle -> StallF=StallD=0, FlushD=FlushE=1. An outstanding MDU op still completes on schedule.
- Async reset mid-op: assert reset 2 cycles after issue -> MduBusy=0 and MduDone=0 without waiting for a clock edge; no MduDone pulse follows.
